// File: rtl/delay_drain_fifo_pkg.sv
// delay_drain_fifo_pkg: default geometry shared by the drain FIFO and its users
package delay_drain_fifo_pkg;
    localparam int DDF_DATA_WIDTH = 16;
    localparam int DDF_DELAY      = 2;
    localparam int DDF_DEPTH      = 8;
endpackage

// File: rtl/delay_drain_fifo_mem.sv
// drain_fifo_mem: DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read
module drain_fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    // storage is deliberately not reset; the head is only meaningful while occupied
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/delay_drain_fifo.sv
// delay_drain_fifo: drives a stall-only delay line and drains its valid words into a FWFT FIFO
module delay_drain_fifo
    import delay_drain_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DDF_DATA_WIDTH,
    parameter int DELAY      = DDF_DELAY,
    parameter int DEPTH      = DDF_DEPTH,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  pipe_en,
    input  logic [DATA_WIDTH-1:0] d_pipe,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [ADDR_W:0]       count
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE  = 1;
    logic [DELAY-1:0]  vld_sr_q, vld_sr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              push, pop;
    // the line only advances while the FIFO can absorb whatever reaches its end
    assign pipe_en = (count_q != FULL) && !flush;
    assign s_ready = pipe_en;
    assign m_valid = count_q != '0;
    assign count   = count_q;
    // next-state for validity shadow, pointers and occupancy; flush overrides everything
    always_comb begin
        push     = pipe_en && vld_sr_q[DELAY-1];
        pop      = m_valid && m_ready;
        vld_sr_d = flush ? '0 : pipe_en ? DELAY'({vld_sr_q, s_valid}) : vld_sr_q;
        wr_ptr_d = flush ? '0 : wr_ptr_q + ADDR_W'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + ADDR_W'(pop);
        count_d  = flush ? '0 : (push && !pop) ? count_q + ONE
                 : (pop && !push) ? count_q - ONE : count_q;
    end
    // state registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_sr_q <= vld_sr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    drain_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (d_pipe),
        .raddr_i (rd_ptr_q),
        .rdata_o (m_data)
    );
endmodule
